// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_adder_pkg;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder assembled from two half adders; the only datapath cell
// the serial controller reuses for every bit position.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic w_s1, w_c1, w_c2;

    half_adder u_ha0 (.a(a),    .b(b),   .s(w_s1), .c(w_c1));
    half_adder u_ha1 (.a(w_s1), .b(cin), .s(s),    .c(w_c2));

    assign cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: LSB-first through one shared full-adder cell, with a
// start/busy/done handshake and registered result.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_cy, r_carry, r_busy, r_done;

    logic             w_s, w_c, w_last;
    logic [WIDTH:0]   w_cat;

    full_adder u_fa (.a(r_a[0]), .b(r_b[0]), .cin(r_cy), .s(w_s), .cout(w_c));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at sum[0].
    assign w_cat  = {w_s, r_sum} >> 1;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_cy    <= 1'b0;
                        r_carry <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum <= w_cat[WIDTH-1:0];
                    r_cy  <= w_c;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_carry <= w_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign sum   = r_sum;
    assign carry = r_carry;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1
// against plain-arithmetic expectations.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       s8, s1;
    logic [7:0] a8, b8, sum8;
    logic [0:0] a1, b1, sum1;
    logic       busy8, done8, carry8, busy1, done1, carry1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(s1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for done with a cycle bound; returns edges after E0 and busy cycles seen.
    task automatic wait_done8(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!done8 && n < 40) begin
            if (busy8) nb++;
            tick();
            n++;
        end
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input string tag);
        logic [8:0] exp;
        int n, nb;
        exp = {1'b0, ta} + {1'b0, tb_v};
        a8 = ta; b8 = tb_v; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        chk({tag, "_busy_after_accept"}, busy8, 1);
        chk({tag, "_done_after_accept"}, done8, 0);
        a8 = 8'($urandom); b8 = 8'($urandom);
        wait_done8(n, nb);
        chk({tag, "_latency"}, n + 1, 9);
        chk({tag, "_busy_cycles"}, nb, 8);
        chk({tag, "_busy_with_done"}, busy8, 0);
        chk({tag, "_sum"}, sum8, exp[7:0]);
        chk({tag, "_carry"}, carry8, exp[8]);
        tick();
        chk({tag, "_done_pulse"}, done8, 0);
        chk({tag, "_sum_held"}, {carry8, sum8}, exp);
    endtask

    initial begin
        int n, nb;
        logic [1:0] e1;
        reset_n = 1'b0;
        s8 = 1'b0; s1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        #12;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_carry", carry8, 0);
        chk("rst_w1", {busy1, done1, sum1, carry1}, 0);
        reset_n = 1'b1;

        run8(8'h00, 8'h00, "zero");
        run8(8'hFF, 8'h01, "ff_01");
        run8(8'hA5, 8'h5A, "a5_5a");

        // start held high: no restart in RUN/DONE, next accept at E0+10
        a8 = 8'h80; b8 = 8'h80; s8 = 1'b1;
        tick();
        chk("hold_busy", busy8, 1);
        a8 = 8'h01; b8 = 8'h02;
        wait_done8(n, nb);
        chk("hold_latency", n + 1, 9);
        chk("hold_sum", sum8, 8'h00);
        chk("hold_carry", carry8, 1);
        tick();
        chk("hold_no_restart_busy", busy8, 0);
        chk("hold_no_restart_done", done8, 0);
        tick();
        chk("hold_accept_e10", busy8, 1);
        s8 = 1'b0;
        wait_done8(n, nb);
        chk("hold2_sum", {carry8, sum8}, 9'h003);

        // reset mid-run aborts
        tick();
        a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b1;
        tick();
        s8 = 1'b0;
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_carry", carry8, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        chk("abort_idle", busy8, 0);
        run8(8'h0F, 8'h01, "after_abort");

        for (int i = 0; i < 16; i++) begin
            run8(8'($urandom), 8'($urandom), "rand");
        end

        // WIDTH=1 exhaustive
        for (int i = 0; i < 4; i++) begin
            a1 = 1'(i >> 1); b1 = 1'(i);
            e1 = {1'b0, a1} + {1'b0, b1};
            s1 = 1'b1;
            tick();
            s1 = 1'b0;
            chk("w1_busy", busy1, 1);
            tick();
            chk("w1_done", done1, 1);
            chk("w1_busy_low", busy1, 0);
            chk("w1_result", {carry1, sum1}, e1);
            tick();
            chk("w1_done_pulse", done1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. Adds two WIDTH-bit operands LSB-first, one bit per clock, through a single full-adder cell built from two `half_adder` instances, so the shared 1-bit datapath is reused across all bit positions. It exposes a start/busy/done handshake so the lab top level or a test sequencer can request additions and collect the WIDTH-bit sum plus carry-out.

## Interface
- `WIDTH`, default 8, operand and sum width in bits; legal range 1..32.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request an addition; sampled only in IDLE.
- `a` input WIDTH: operand A; captured on the accepting edge.
- `b` input WIDTH: operand B; captured on the accepting edge.
- `busy` output 1: high while bits are being processed (RUN).
- `done` output 1: one-cycle pulse; `sum` and `carry` are valid.
- `sum` output WIDTH: result bits; held until the next accepted start.
- `carry` output 1: carry-out of bit WIDTH-1; held with `sum`.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE: if `start`=1 at an edge, the edge performs all of the following:
  - latch `a` and `b` into operand shift registers;
  - clear the internal carry flop, bit counter and `sum`;
  - move to RUN.
- With `start`=0, IDLE holds.
- RUN: every edge performs all of the following:
  - feed operand LSBs and the carry flop into the full-adder cell;
  - shift the sum bit into `sum` from the MSB side (after WIDTH shifts, bit 0 is at `sum[0]`);
  - load the cell carry into the carry flop;
  - shift both operands right by one;
  - increment the counter.
- At the edge that processes bit WIDTH-1, the final cell carry goes to `carry` and the FSM moves to DONE.
- DONE: `done`=1 for exactly one cycle, then the FSM moves to IDLE unconditionally.
- `start` is ignored in RUN and DONE. No queuing.
- Arithmetic: {`carry`,`sum`} = `a` + `b` modulo 2^(WIDTH+1). There is no carry-in.
- Reset asserted mid-operation aborts the addition immediately. All state and outputs return to reset values, and the partial result is discarded.
- Changes on `a`/`b` after the accepting edge have no effect on the result.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `carry`=0, state IDLE, counter 0.
- `start` is accepted at edge E0. `busy`=1 from after E0 through edge E0+WIDTH.
- Bits are processed at edges E0+1 through E0+WIDTH.
- `done`=1 in the cycle after edge E0+WIDTH, with `sum` and `carry` final.
- Latency from accepting edge to `done` is WIDTH+1 edges, i.e. 9 edges for WIDTH=8.
- The earliest next start is accepted at edge E0+WIDTH+2 (back in IDLE).
- `busy` and `done` are never high together. All outputs are registered.

## Structure
- Package `serial_adder_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} state_t`;
  - the max-WIDTH constant.
- Counter width is `$clog2(WIDTH+1)`, local to the module.
- Sub-module `full_adder`: ports a, b, cin, s, cout. It is two `half_adder` instances plus an OR of their carries, and is instantiated once in the controller.

## Test plan
- WIDTH=8, a=8'h00, b=8'h00, start pulse -> `busy` high 8 cycles; `done` at edge 9; `sum`=8'h00, `carry`=0.
- a=8'hFF, b=8'h01 -> `sum`=8'h00, `carry`=1; `done` for exactly one cycle; `sum` held afterwards.
- a=8'hA5, b=8'h5A; operands changed to 8'h00 one cycle after start -> `sum`=8'hFF, `carry`=0.
- `start` held high continuously with a=8'h80, b=8'h80 -> first result `sum`=8'h00, `carry`=1. No restart during RUN/DONE. The next accept happens at edge E0+10.
- `reset_n` pulsed low at edge E0+4 of a run -> all outputs 0, state IDLE. A following start with a=8'h0F, b=8'h01 gives `sum`=8'h10, `carry`=0.
- WIDTH=1, exhaustive a,b in {0,1} -> {`carry`,`sum`} = 00, 01, 01, 10; `done` two edges after each start.
